// File: rtl/softcore_cpu_debug_host_shifter.sv
// Host-side virtual-JTAG sequencer for the CPU debug slave.
// Takes one debug command (IR value + DR payload) on a valid/ready port. It plays
// UIR -> CDR -> SHIFT -> UDR -> RTI on the slave's virtual-JTAG pins, then returns
// the DR bits captured from tdo on a valid/ready response port.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ir, cmd_dr, cmd_skip_ir payload
//   rsp_valid/rsp_ready   response handshake; rsp_dr captured bits (bit0 first captured)
//   vj_*                  virtual-JTAG pins towards the debug slave
module softcore_cpu_debug_host_shifter #(
   parameter int unsigned DR_WIDTH   = 38,
   parameter int unsigned IR_WIDTH   = 2,
   parameter int unsigned TCK_DIV    = 4,
   parameter int unsigned RTI_CYCLES = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   input  logic                cmd_skip_ir,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic                vj_tck,
   output logic [IR_WIDTH-1:0] vj_ir_in,
   output logic                vj_uir,
   output logic                vj_cdr,
   output logic                vj_sdr,
   output logic                vj_udr,
   output logic                vj_rti,
   output logic                vj_tdi,
   input  logic                vj_tdo
);

   localparam int unsigned DivW   = (TCK_DIV > 2) ? $clog2(TCK_DIV) : 1;
   localparam int unsigned CntMax = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   typedef enum logic [2:0] {
      StIdle,
      StUir,
      StCdr,
      StShift,
      StUdr,
      StRti,
      StResp
   } state_e;

   state_e              state_q, state_d;
   logic [DivW-1:0]     div_q, div_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [DR_WIDTH-1:0] sr_q, sr_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;

   logic tck_end;
   logic in_period;

   assign tck_end   = (div_q == DivW'(TCK_DIV - 1));
   assign in_period = (state_q == StUir) || (state_q == StCdr) || (state_q == StShift) ||
                      (state_q == StUdr) || (state_q == StRti);

   always_comb begin
      state_d  = state_q;
      div_d    = '0;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      ir_d     = ir_q;
      rsp_dr_d = rsp_dr_q;

      // Divider only runs while a TCK period is being played; idle/resp keep TCK low.
      if (in_period && !tck_end) begin
         div_d = div_q + DivW'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               sr_d  = cmd_dr;
               cnt_d = '0;
               if (cmd_skip_ir) begin
                  state_d = StCdr;
               end else begin
                  ir_d    = cmd_ir;
                  state_d = StUir;
               end
            end
         end
         StUir: begin
            if (tck_end) state_d = StCdr;
         end
         StCdr: begin
            if (tck_end) state_d = StShift;
         end
         StShift: begin
            // tdo is sampled in the last high-TCK cycle; tdi follows sr[0] from the next period.
            if (tck_end) begin
               sr_d = {vj_tdo, sr_q[DR_WIDTH-1:1]};
               if (cnt_q == CntW'(DR_WIDTH - 1)) begin
                  cnt_d   = '0;
                  state_d = StUdr;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StUdr: begin
            if (tck_end) state_d = StRti;
         end
         StRti: begin
            if (tck_end) begin
               if (cnt_q == CntW'(RTI_CYCLES - 1)) begin
                  cnt_d    = '0;
                  rsp_dr_d = sr_q;
                  state_d  = StResp;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         div_q    <= '0;
         cnt_q    <= '0;
         sr_q     <= '0;
         ir_q     <= '0;
         rsp_dr_q <= '0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         sr_q     <= sr_d;
         ir_q     <= ir_d;
         rsp_dr_q <= rsp_dr_d;
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StResp);
   assign rsp_dr    = rsp_dr_q;
   assign vj_tck    = (div_q >= DivW'(TCK_DIV / 2));
   assign vj_ir_in  = ir_q;
   assign vj_uir    = (state_q == StUir);
   assign vj_cdr    = (state_q == StCdr);
   assign vj_sdr    = (state_q == StShift);
   assign vj_udr    = (state_q == StUdr);
   assign vj_rti    = (state_q == StIdle) || (state_q == StRti) || (state_q == StResp);
   assign vj_tdi    = (state_q == StShift) && sr_q[0];

endmodule

// File: tb/tb_softcore_cpu_debug_host_shifter.sv
// Bench for softcore_cpu_debug_host_shifter with default parameters.
module tb_softcore_cpu_debug_host_shifter;

   localparam int unsigned DW = 38;
   localparam int unsigned IW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [IW-1:0] cmd_ir;
   logic [DW-1:0] cmd_dr;
   logic          cmd_skip_ir;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_dr;
   logic          vj_tck;
   logic [IW-1:0] vj_ir_in;
   logic          vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti, vj_tdi, vj_tdo;

   always #5 clk = ~clk;

   softcore_cpu_debug_host_shifter dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_ir      (cmd_ir),
      .cmd_dr      (cmd_dr),
      .cmd_skip_ir (cmd_skip_ir),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_dr      (rsp_dr),
      .vj_tck      (vj_tck),
      .vj_ir_in    (vj_ir_in),
      .vj_uir      (vj_uir),
      .vj_cdr      (vj_cdr),
      .vj_sdr      (vj_sdr),
      .vj_udr      (vj_udr),
      .vj_rti      (vj_rti),
      .vj_tdi      (vj_tdi),
      .vj_tdo      (vj_tdo)
   );

   // tdo source: 0 = loopback (tdi delayed one TCK period), 1 = constant 0, 2 = constant 1.
   logic [1:0] tdo_mode = 2'd0;
   logic       loop_q, tck_d, tdi_d;
   assign vj_tdo = (tdo_mode == 2'd0) ? loop_q : (tdo_mode == 2'd2);

   // Loopback flop takes the period's tdi in the cycle after TCK falls.
   always @(posedge clk) begin
      if (reset) begin
         loop_q <= 1'b0;
         tck_d  <= 1'b0;
         tdi_d  <= 1'b0;
      end else begin
         tck_d <= vj_tck;
         tdi_d <= vj_tdi;
         if (tck_d && !vj_tck) loop_q <= tdi_d;
      end
   end

   // tdi must never change in a cycle where TCK is high.
   int   tdi_viol = 0;
   logic prev_tdi;
   always @(negedge clk) begin
      prev_tdi <= vj_tdi;
      if (!reset && vj_tck && (vj_tdi !== prev_tdi)) tdi_viol <= tdi_viol + 1;
   end

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h required %0h", name, got, exp);
   endtask

   // Called at a negedge in IDLE; returns at the negedge of cycle 1 (after the accept edge).
   task automatic issue(input logic [IW-1:0] ir, input logic [DW-1:0] dr, input logic skip);
      cmd_ir      = ir;
      cmd_dr      = dr;
      cmd_skip_ir = skip;
      cmd_valid   = 1'b1;
      @(negedge clk);
      cmd_valid   = 1'b0;
   endtask

   // lat = index of the first cycle with rsp_valid high (accept cycle = 0).
   task automatic wait_rsp(output int lat, output int n_uir, output int n_cdr,
                           output int n_sdr, output int n_udr, output int n_rdy,
                           output int n_tck);
      lat = 1; n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rdy = 0; n_tck = 0;
      while (!rsp_valid && lat < 1000) begin
         n_uir += int'(vj_uir);
         n_cdr += int'(vj_cdr);
         n_sdr += int'(vj_sdr);
         n_udr += int'(vj_udr);
         n_rdy += int'(cmd_ready);
         n_tck += int'(vj_tck);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic finish_rsp(input string tag);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_ready_after"}, 64'(cmd_ready), 64'(1));
      check({tag, "_valid_after"}, 64'(rsp_valid), 64'(0));
   endtask

   typedef struct {
      logic [IW-1:0] ir;
      logic [DW-1:0] dr;
      logic          skip;
      logic [1:0]    mode;
      logic [DW-1:0] exp_dr;
      logic [IW-1:0] exp_ir;
      int            exp_lat;
      int            exp_uir;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int lat, n_uir, n_cdr, n_sdr, n_udr, n_rdy, n_tck;
      int bad;
      int acc_cyc[2];
      int hs_cyc[2];
      logic [DW-1:0] got[2];
      int n_acc, n_hs;

      vecs[0] = '{ir: 2'b01, dr: 38'h2A_5A5A_A5A5, skip: 1'b0, mode: 2'd0,
                  exp_dr: 38'h14_B4B5_4B4A, exp_ir: 2'b01, exp_lat: 169, exp_uir: 4};
      vecs[1] = '{ir: 2'b10, dr: 38'h00_1234_5678, skip: 1'b1, mode: 2'd2,
                  exp_dr: 38'h3F_FFFF_FFFF, exp_ir: 2'b01, exp_lat: 165, exp_uir: 0};
      vecs[2] = '{ir: 2'b11, dr: 38'h3F_0000_FFFF, skip: 1'b0, mode: 2'd0,
                  exp_dr: 38'h3E_0001_FFFE, exp_ir: 2'b11, exp_lat: 169, exp_uir: 4};
      vecs[3] = '{ir: 2'b00, dr: 38'h15_5555_5555, skip: 1'b0, mode: 2'd1,
                  exp_dr: 38'h00_0000_0000, exp_ir: 2'b00, exp_lat: 169, exp_uir: 4};

      // Reset held 3 cycles with a command offered: nothing may be accepted.
      reset = 1'b1; rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_ir = 2'b11; cmd_dr = '1; cmd_skip_ir = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_rti", 64'(vj_rti), 64'(1));
      check("rst_tck", 64'(vj_tck), 64'(0));
      check("rst_strobes", 64'({vj_uir, vj_cdr, vj_sdr, vj_udr, vj_tdi}), 64'(0));
      check("rst_ir_dr", 64'({vj_ir_in, rsp_dr}), 64'(0));
      cmd_valid = 1'b0; reset = 1'b0;
      @(negedge clk);
      check("post_rst_idle", 64'({cmd_ready, vj_uir, vj_cdr}), 64'(3'b100));

      for (int i = 0; i < 4; i++) begin
         tdo_mode = vecs[i].mode;
         check($sformatf("v%0d_ready", i), 64'(cmd_ready), 64'(1));
         issue(vecs[i].ir, vecs[i].dr, vecs[i].skip);
         wait_rsp(lat, n_uir, n_cdr, n_sdr, n_udr, n_rdy, n_tck);
         check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         check($sformatf("v%0d_rsp_dr", i), 64'(rsp_dr), 64'(vecs[i].exp_dr));
         check($sformatf("v%0d_ir_in", i), 64'(vj_ir_in), 64'(vecs[i].exp_ir));
         check($sformatf("v%0d_uir_cyc", i), 64'(n_uir), 64'(vecs[i].exp_uir));
         check($sformatf("v%0d_cdr_cyc", i), 64'(n_cdr), 64'(4));
         check($sformatf("v%0d_sdr_cyc", i), 64'(n_sdr), 64'(152));
         check($sformatf("v%0d_udr_cyc", i), 64'(n_udr), 64'(4));
         check($sformatf("v%0d_busy_ready", i), 64'(n_rdy), 64'(0));
         check($sformatf("v%0d_tck_hi", i), 64'(n_tck), 64'((vecs[i].exp_lat - 1) / 2));
         finish_rsp($sformatf("v%0d", i));
      end

      // Backpressure: response held for 20 cycles.
      tdo_mode = 2'd2;
      issue(2'b10, 38'h01_2345_6789, 1'b0);
      wait_rsp(lat, n_uir, n_cdr, n_sdr, n_udr, n_rdy, n_tck);
      check("bp_latency", 64'(lat), 64'(169));
      check("bp_rsp_dr", 64'(rsp_dr), 64'(38'h3F_FFFF_FFFF));
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_dr !== 38'h3F_FFFF_FFFF || cmd_ready !== 1'b0 ||
             vj_rti !== 1'b1) bad++;
      end
      check("bp_stable", 64'(bad), 64'(0));
      finish_rsp("bp");

      // Reset in the middle of the 10th shifted bit.
      tdo_mode = 2'd0;
      issue(2'b01, 38'h2A_5A5A_A5A5, 1'b0);
      for (int c = 0; c < 100 && !vj_sdr; c++) @(negedge clk);
      check("mr_reached_shift", 64'(vj_sdr), 64'(1));
      repeat (37) @(negedge clk);
      reset = 1'b1;
      cmd_valid = 1'b1; cmd_ir = 2'b10; cmd_skip_ir = 1'b0;
      @(negedge clk);
      check("mr_idle", 64'({cmd_ready, rsp_valid, vj_sdr, vj_tck, vj_rti, vj_tdi}),
            64'(6'b100010));
      check("mr_regs", 64'({vj_ir_in, rsp_dr}), 64'(0));
      cmd_valid = 1'b0; reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || vj_uir !== 1'b0 || cmd_ready !== 1'b1) bad++;
      end
      check("mr_quiet", 64'(bad), 64'(0));
      issue(2'b11, 38'h3F_0000_FFFF, 1'b0);
      wait_rsp(lat, n_uir, n_cdr, n_sdr, n_udr, n_rdy, n_tck);
      check("mr_latency", 64'(lat), 64'(169));
      check("mr_rsp_dr", 64'(rsp_dr), 64'(38'h3E_0001_FFFE));
      finish_rsp("mr");

      // Back-to-back: cmd_valid stays high across two commands, rsp_ready always high.
      tdo_mode = 2'd0;
      acc_cyc = '{-1, -1}; hs_cyc = '{-1, -1}; got = '{'0, '0};
      n_acc = 0; n_hs = 0;
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_ir = 2'b01; cmd_dr = 38'h00_0000_0003; cmd_skip_ir = 1'b0;
      for (int c = 0; c < 1000 && n_hs < 2; c++) begin
         if (cmd_valid && cmd_ready && n_acc < 2) begin acc_cyc[n_acc] = c; n_acc++; end
         if (rsp_valid && rsp_ready) begin hs_cyc[n_hs] = c; got[n_hs] = rsp_dr; n_hs++; end
         @(negedge clk);
         if (n_acc == 1) cmd_dr = 38'h10_0000_0001;
         if (n_acc == 2) cmd_valid = 1'b0;
      end
      cmd_valid = 1'b0; rsp_ready = 1'b0;
      check("b2b_responses", 64'(n_hs), 64'(2));
      check("b2b_latency", 64'(hs_cyc[0] - acc_cyc[0]), 64'(169));
      check("b2b_second_accept", 64'(acc_cyc[1] - hs_cyc[0]), 64'(1));
      check("b2b_rsp0", 64'(got[0]), 64'(38'h00_0000_0006));
      check("b2b_rsp1", 64'(got[1]), 64'(38'h20_0000_0002));

      @(negedge clk);
      check("tdi_stable_high", 64'(tdi_viol), 64'(0));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
